// File: rtl/gba_backup_mem.sv
// gba_backup_mem: GBA cartridge backup (SRAM / flash) emulation on top of SDRAM.
// Maps the 64KB backup window onto a 128KB SDRAM region and emulates the flash
// command set, bank switching, byte program and sector / chip erase.
// Optional build macro GBA_BACKUP_STATUS_EN: while an erase runs, reads are
// served between erase words and return the status byte 8'h00.
module gba_backup_mem #(
    parameter logic [8:0] SDRAM_BASE = 9'b1000_0001_0,
    parameter int         SDRAM_LAT  = 3,
    parameter logic [7:0] MFR_ID     = 8'h62,
    parameter logic [7:0] DEV_ID     = 8'h13,
    parameter int         SECTOR_HW  = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [1:0]  backup_type,
    input  logic [16:0] addr,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] din,
    input  logic        setbank1,
    output logic        ready,
    output logic [7:0]  dout,
    output logic        busy,
    output logic        dirty,
    input  logic        clear_dirty,
    output logic        sdram_rd,
    output logic        sdram_wr,
    output logic [24:0] sdram_addr,
    output logic [15:0] sdram_d,
    input  logic [15:0] sdram_q,
    output logic [1:0]  sdram_ds
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_EWR, S_EWAIT} state_t;
    typedef enum logic [1:0] {CMD_IDLE, CMD_AA, CMD_55} cmd_t;
    typedef enum logic [2:0] {M_NORMAL, M_ID, M_ERASE, M_WRITE, M_BANK} mode_t;

    localparam logic [3:0] LAT_M1 = 4'(SDRAM_LAT - 1);

    state_t      state;
    cmd_t        cmd;
    mode_t       mode;
    logic        bank;
    logic [3:0]  lat;
    logic [15:0] count;
    logic [15:0] e_addr;
    logic        erase_active;
    logic        rd_op;
    logic        rd_sdram;
    logic        rd_hi;
    logic [7:0]  rd_val;

    logic [15:0] off;
    logic [7:0]  wbyte;
    logic [15:0] wr_d;
    logic [1:0]  wr_ds;
    logic [15:0] flash_hw;
    logic [15:0] sram_hw;
    logic [15:0] sec_start;
    logic [15:0] e_next;
    logic        chip_hit;
    logic        sector_hit;
    logic        erase_go;
    logic [15:0] er_start;
    logic [15:0] er_cnt;
    logic        unused_loader_bit;

    // addr[16] only matters to the loader path that lives outside this block
    assign unused_loader_bit = addr[16];

    assign off       = addr[15:0];
    assign wr_d      = addr[1] ? din[31:16] : din[15:0];
    assign wr_ds     = addr[0] ? 2'b10 : 2'b01;
    assign flash_hw  = {bank, off[15:1]};
    assign sram_hw   = {2'b00, off[14:1]};
    assign sec_start = {bank, off[15:1]} & ~16'(SECTOR_HW - 1);
    assign e_next    = e_addr + 16'd1;

    // Byte selection from the 32-bit CPU bus and erase command decoding
    always_comb begin
        case (addr[1:0])
            2'd0:    wbyte = din[7:0];
            2'd1:    wbyte = din[15:8];
            2'd2:    wbyte = din[23:16];
            default: wbyte = din[31:24];
        endcase
        chip_hit   = (off == 16'h5555) && (wbyte == 8'h10);
        sector_hit = (off[11:0] == 12'h000) && (wbyte == 8'h30);
        erase_go   = backup_type[1] && write && (mode == M_ERASE) && (cmd == CMD_55)
                     && (chip_hit || sector_hit);
        er_start   = chip_hit ? 16'h0000 : sec_start;
        er_cnt     = chip_hit ? (backup_type[0] ? 16'hFFFF : 16'h7FFF) : 16'(SECTOR_HW - 1);
    end

    // Access, flash command and erase sequencing with registered SDRAM requests
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cmd          <= CMD_IDLE;
            mode         <= M_NORMAL;
            bank         <= 1'b0;
            lat          <= 4'd0;
            count        <= 16'd0;
            e_addr       <= 16'd0;
            erase_active <= 1'b0;
            rd_op        <= 1'b0;
            rd_sdram     <= 1'b0;
            rd_hi        <= 1'b0;
            rd_val       <= 8'hFF;
            ready        <= 1'b0;
            busy         <= 1'b0;
            dirty        <= 1'b0;
            dout         <= 8'hFF;
            sdram_rd     <= 1'b0;
            sdram_wr     <= 1'b0;
            sdram_addr   <= 25'd0;
            sdram_d      <= 16'd0;
            sdram_ds     <= 2'b00;
        end else if (ce) begin
            sdram_rd <= 1'b0;
            sdram_wr <= 1'b0;
            ready    <= 1'b0;
            if (clear_dirty) dirty <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        state    <= S_WAIT;
                        busy     <= 1'b1;
                        lat      <= LAT_M1;
                        ready    <= (SDRAM_LAT == 1);
                        rd_op    <= !write;
                        rd_sdram <= 1'b0;
                        rd_hi    <= addr[0];
                        rd_val   <= 8'hFF;
                        sdram_d  <= wr_d;
                        sdram_ds <= wr_ds;
                        if (setbank1 && write && off == 16'hFFFF) bank <= 1'b1;
`ifdef GBA_BACKUP_STATUS_EN
                        if (erase_active) rd_val <= 8'h00;
                        else
`endif
                        if (backup_type == 2'd1) begin
                            sdram_addr <= {SDRAM_BASE, sram_hw};
                            if (write) begin
                                sdram_wr <= 1'b1;
                                dirty    <= 1'b1;
                            end else begin
                                sdram_rd <= 1'b1;
                                rd_sdram <= 1'b1;
                            end
                        end else if (backup_type[1]) begin
                            if (!write) begin
                                if (mode == M_ID && off[15:1] == 15'd0) begin
                                    rd_val <= off[0] ? DEV_ID : MFR_ID;
                                end else begin
                                    sdram_addr <= {SDRAM_BASE, flash_hw};
                                    sdram_rd   <= 1'b1;
                                    rd_sdram   <= 1'b1;
                                end
                            end else if (mode == M_WRITE) begin
                                sdram_addr <= {SDRAM_BASE, flash_hw};
                                sdram_wr   <= 1'b1;
                                dirty      <= 1'b1;
                                mode       <= M_NORMAL;
                            end else if (mode == M_BANK && off == 16'h0000) begin
                                bank <= backup_type[0] & din[0];
                                mode <= M_NORMAL;
                            end else begin
                                case (cmd)
                                    CMD_IDLE: begin
                                        if (off == 16'h5555 && wbyte == 8'hAA) cmd <= CMD_AA;
                                        else if (wbyte == 8'hF0) mode <= M_NORMAL;
                                    end
                                    CMD_AA: begin
                                        if (off == 16'h2AAA && wbyte == 8'h55) cmd <= CMD_55;
                                        else cmd <= CMD_IDLE;
                                    end
                                    default: begin
                                        cmd <= CMD_IDLE;
                                        if (off == 16'h5555) begin
                                            case (wbyte)
                                                8'h90:   mode <= M_ID;
                                                8'hF0:   mode <= M_NORMAL;
                                                8'h80:   mode <= M_ERASE;
                                                8'hA0:   mode <= M_WRITE;
                                                8'hB0:   mode <= M_BANK;
                                                default: ;
                                            endcase
                                        end
                                        if (erase_go) begin
                                            state        <= S_EWR;
                                            ready        <= 1'b0;
                                            erase_active <= 1'b1;
                                            mode         <= M_NORMAL;
                                            dirty        <= 1'b1;
                                            e_addr       <= er_start;
                                            count        <= er_cnt;
                                            sdram_addr   <= {SDRAM_BASE, er_start};
                                            sdram_wr     <= 1'b1;
                                            sdram_d      <= 16'hFFFF;
                                            sdram_ds     <= 2'b11;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
`ifdef GBA_BACKUP_STATUS_EN
                    else if (erase_active) begin
                        state      <= S_EWR;
                        busy       <= 1'b1;
                        sdram_addr <= {SDRAM_BASE, e_addr};
                        sdram_wr   <= 1'b1;
                        sdram_d    <= 16'hFFFF;
                        sdram_ds   <= 2'b11;
                    end
`endif
                end
                S_WAIT: begin
                    if (lat != 4'd0) begin
                        lat   <= lat - 4'd1;
                        ready <= (lat == 4'd1);
                    end else begin
                        state <= S_RESP;
                        busy  <= 1'b0;
                        if (rd_op) dout <= rd_sdram ? (rd_hi ? sdram_q[15:8] : sdram_q[7:0]) : rd_val;
                    end
                end
                S_RESP: state <= S_IDLE;
                S_EWR: begin
                    state <= S_EWAIT;
                    lat   <= LAT_M1;
                end
                S_EWAIT: begin
                    if (lat != 4'd0) begin
                        lat <= lat - 4'd1;
                    end else if (count == 16'd0) begin
                        erase_active <= 1'b0;
                        state        <= S_WAIT;
                        lat          <= 4'd0;
                        ready        <= 1'b1;
                        rd_op        <= 1'b0;
                    end else begin
                        count  <= count - 16'd1;
                        e_addr <= e_next;
`ifdef GBA_BACKUP_STATUS_EN
                        state  <= S_IDLE;
                        busy   <= 1'b0;
`else
                        state      <= S_EWR;
                        sdram_wr   <= 1'b1;
                        sdram_addr <= {SDRAM_BASE, e_next};
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gba_backup_mem.sv
// tb_gba_backup_mem: directed scoreboard bench for gba_backup_mem with a
// behavioural SDRAM model (registered read data, byte-strobed writes).
module tb_gba_backup_mem;

    localparam int         LAT  = 3;
    localparam logic [8:0] BASE = 9'b1000_0001_0;

    logic        clk;
    logic        reset;
    logic        ce;
    logic [1:0]  backup_type;
    logic [16:0] addr;
    logic        valid;
    logic        write;
    logic [31:0] din;
    logic        setbank1;
    logic        ready;
    logic [7:0]  dout;
    logic        busy;
    logic        dirty;
    logic        clear_dirty;
    logic        sdram_rd;
    logic        sdram_wr;
    logic [24:0] sdram_addr;
    logic [15:0] sdram_d;
    logic [15:0] sdram_q;
    logic [1:0]  sdram_ds;

    typedef struct {
        bit         is_read;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [int];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wr_mark = 0;
    int          non_erase_cnt = 0;
    logic [24:0] last_rd_addr;
    logic [1:0]  last_rd_ds;
    logic [24:0] last_wr_addr;
    logic [15:0] last_wr_d;
    logic [1:0]  last_wr_ds;
    logic [24:0] first_wr_addr;

    int lc;
    int bl;
    int mark;
    int mark2;

    gba_backup_mem #(
        .SDRAM_BASE(BASE),
        .SDRAM_LAT(LAT),
        .MFR_ID(8'h62),
        .DEV_ID(8'h13),
        .SECTOR_HW(2048)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .backup_type(backup_type),
        .addr(addr),
        .valid(valid),
        .write(write),
        .din(din),
        .setbank1(setbank1),
        .ready(ready),
        .dout(dout),
        .busy(busy),
        .dirty(dirty),
        .clear_dirty(clear_dirty),
        .sdram_rd(sdram_rd),
        .sdram_wr(sdram_wr),
        .sdram_addr(sdram_addr),
        .sdram_d(sdram_d),
        .sdram_q(sdram_q),
        .sdram_ds(sdram_ds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Untouched SDRAM words read as {~index[7:0], index[7:0]}
    function automatic logic [15:0] memRead(input logic [24:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {~a[7:0], a[7:0]};
    endfunction

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // SDRAM read data path: registered one cycle after the request
    always @(posedge clk) begin
        if (sdram_rd) sdram_q <= memRead(sdram_addr);
    end

    // SDRAM request observer and write model
    always @(negedge clk) begin
        logic [15:0] w;
        if (sdram_rd) begin
            rd_cnt++;
            last_rd_addr = sdram_addr;
            last_rd_ds   = sdram_ds;
        end
        if (sdram_wr) begin
            if (wr_cnt == wr_mark) first_wr_addr = sdram_addr;
            if (sdram_ds !== 2'b11 || sdram_d !== 16'hFFFF) non_erase_cnt++;
            wr_cnt++;
            last_wr_addr = sdram_addr;
            last_wr_d    = sdram_d;
            last_wr_ds   = sdram_ds;
            w = memRead(sdram_addr);
            if (sdram_ds[0]) w[7:0]  = sdram_d[7:0];
            if (sdram_ds[1]) w[15:8] = sdram_d[15:8];
            mem[int'(sdram_addr)] = w;
        end
    end

    // Scoreboard monitor: pops one expectation per ready pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ready: got ready=1 with no pending request, required ready=0");
                end else begin
                    e = sbq.pop_front();
                    @(negedge clk);
                    checkOutput({e.name, "_ready_pulse"}, 32'(ready), 32'd0);
                    if (e.is_read) checkOutput({e.name, "_dout"}, 32'(dout), 32'(e.data));
                end
            end
        end
    end

    // One access: push the expectation, drive valid for one cycle, wait for ready
    task automatic applyStimulus(input bit wr, input logic [16:0] a, input logic [31:0] d,
                                 input logic [7:0] exp, input string nm, input int max_cyc,
                                 output int lat_cyc, output int busy_low);
        exp_t e;
        @(negedge clk);
        e.is_read = !wr;
        e.data    = exp;
        e.name    = nm;
        sbq.push_back(e);
        addr  = a;
        write = wr;
        din   = d;
        valid = 1'b1;
        @(negedge clk);
        valid    = 1'b0;
        lat_cyc  = 1;
        busy_low = 0;
        while (ready !== 1'b1 && lat_cyc < max_cyc) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            lat_cyc++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no ready within %0d cycles, required ready", nm, max_cyc);
        end
        @(negedge clk);
    endtask

    task automatic flashCmd(input logic [16:0] a, input logic [7:0] b, input string nm);
        int l;
        int q;
        applyStimulus(1'b1, a, {4{b}}, 8'h00, nm, 20, l, q);
    endtask

    task automatic unlock();
        flashCmd(17'h05555, 8'hAA, "unlock_aa");
        flashCmd(17'h02AAA, 8'h55, "unlock_55");
    endtask

    // Watchdog so the run always terminates
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        ce          = 1'b1;
        backup_type = 2'd3;
        addr        = 17'd0;
        valid       = 1'b0;
        write       = 1'b0;
        din         = 32'd0;
        setbank1    = 1'b0;
        clear_dirty = 1'b0;
        sdram_q     = 16'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_dout", 32'(dout), 32'hFF);
        checkOutput("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        checkOutput("rst_dirty", 32'(dirty), 32'd0);
        checkOutput("rst_sdram_wr", 32'(sdram_wr), 32'd0);
        reset = 1'b0;

        // Plain flash read, high byte lane
        mark = rd_cnt;
        applyStimulus(1'b0, 17'h00123, 32'd0, 8'h6E, "read_0123", 20, lc, bl);
        checkOutput("read_latency", 32'(lc), 32'(LAT));
        checkOutput("read_busy_low", 32'(bl), 32'd0);
        checkOutput("read_rd_count", 32'(rd_cnt - mark), 32'd1);
        checkOutput("read_addr", 32'(last_rd_addr), 32'h1020091);
        checkOutput("read_ds", 32'(last_rd_ds), 32'h2);

        // ID mode entry, ID reads without SDRAM traffic, exit with F0
        unlock();
        flashCmd(17'h05555, 8'h90, "id_enter");
        mark = rd_cnt;
        applyStimulus(1'b0, 17'h00000, 32'd0, 8'h62, "id_mfr", 20, lc, bl);
        applyStimulus(1'b0, 17'h00001, 32'd0, 8'h13, "id_dev", 20, lc, bl);
        checkOutput("id_no_sdram_rd", 32'(rd_cnt - mark), 32'd0);
        flashCmd(17'h05555, 8'hF0, "id_exit");
        mark = rd_cnt;
        applyStimulus(1'b0, 17'h00000, 32'd0, 8'h00, "normal_read0", 20, lc, bl);
        checkOutput("normal_rd_count", 32'(rd_cnt - mark), 32'd1);

        // Broken unlock sequence must not enter ID mode
        flashCmd(17'h05555, 8'hAA, "abort_aa");
        flashCmd(17'h02AAA, 8'h12, "abort_12");
        flashCmd(17'h02AAA, 8'h55, "abort_55");
        flashCmd(17'h05555, 8'h90, "abort_90");
        applyStimulus(1'b0, 17'h00000, 32'd0, 8'h00, "abort_read0", 20, lc, bl);
        applyStimulus(1'b0, 17'h00001, 32'd0, 8'hFF, "abort_read1", 20, lc, bl);

        // Bank 1 select, then byte program
        unlock();
        flashCmd(17'h05555, 8'hB0, "bank_cmd");
        flashCmd(17'h00000, 8'h01, "bank_set1");
        unlock();
        flashCmd(17'h05555, 8'hA0, "prog_cmd");
        mark = wr_cnt;
        applyStimulus(1'b1, 17'h00010, {4{8'h5A}}, 8'h00, "prog_5a", 20, lc, bl);
        checkOutput("prog_latency", 32'(lc), 32'(LAT));
        checkOutput("prog_wr_count", 32'(wr_cnt - mark), 32'd1);
        checkOutput("prog_addr", 32'(last_wr_addr), 32'h1028008);
        checkOutput("prog_ds", 32'(last_wr_ds), 32'h1);
        checkOutput("prog_d", 32'(last_wr_d), 32'h5A5A);
        checkOutput("prog_dirty", 32'(dirty), 32'd1);
        @(negedge clk);
        clear_dirty = 1'b1;
        @(negedge clk);
        clear_dirty = 1'b0;
        checkOutput("dirty_cleared", 32'(dirty), 32'd0);

        // Sector erase of 0x3000 in bank 1
        unlock();
        flashCmd(17'h05555, 8'h80, "erase_cmd");
        unlock();
        wr_mark = wr_cnt;
        mark    = non_erase_cnt;
        applyStimulus(1'b1, 17'h03000, {4{8'h30}}, 8'h00, "sector_erase", 12000, lc, bl);
        checkOutput("sector_wr_count", 32'(wr_cnt - wr_mark), 32'd2048);
        checkOutput("sector_first_addr", 32'(first_wr_addr), 32'h1029800);
        checkOutput("sector_last_addr", 32'(last_wr_addr), 32'h1029FFF);
        checkOutput("sector_ffff_only", 32'(non_erase_cnt - mark), 32'd0);
        checkOutput("sector_cycles", 32'(lc), 32'(2048 * (LAT + 1) + 1));
        checkOutput("sector_busy_low", 32'(bl), 32'd0);
        checkOutput("sector_dirty", 32'(dirty), 32'd1);
        applyStimulus(1'b0, 17'h03002, 32'd0, 8'hFF, "erased_read", 20, lc, bl);

        // FLASH64K: bank select is forced to 0
        backup_type = 2'd2;
        unlock();
        flashCmd(17'h05555, 8'hB0, "bank64_cmd");
        flashCmd(17'h00000, 8'h01, "bank64_set");
        unlock();
        flashCmd(17'h05555, 8'hA0, "prog64_cmd");
        mark = wr_cnt;
        applyStimulus(1'b1, 17'h00010, {4{8'h5A}}, 8'h00, "prog64_5a", 20, lc, bl);
        checkOutput("prog64_wr_count", 32'(wr_cnt - mark), 32'd1);
        checkOutput("prog64_addr", 32'(last_wr_addr), 32'h1020008);

        // Chip erase interrupted by reset
        unlock();
        flashCmd(17'h05555, 8'h80, "chip_cmd");
        unlock();
        @(negedge clk);
        wr_mark = wr_cnt;
        addr  = 17'h05555;
        din   = {4{8'h10}};
        write = 1'b1;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("chip_busy", 32'(busy), 32'd1);
        checkOutput("chip_first_addr", 32'(first_wr_addr), 32'h1020000);
        checkOutput("chip_progress", 32'((wr_cnt - wr_mark) >= 8), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("chip_rst_sdram_wr", 32'(sdram_wr), 32'd0);
        checkOutput("chip_rst_busy", 32'(busy), 32'd0);
        checkOutput("chip_rst_dout", 32'(dout), 32'hFF);
        checkOutput("chip_rst_dirty", 32'(dirty), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mark2 = wr_cnt;
        repeat (20) @(negedge clk);
        checkOutput("chip_rst_no_writes", 32'(wr_cnt - mark2), 32'd0);

        // SRAM32K wraps at 32KB
        backup_type = 2'd1;
        mark = wr_cnt;
        applyStimulus(1'b1, 17'h08004, 32'h11223344, 8'h00, "sram_wr", 20, lc, bl);
        checkOutput("sram_wr_count", 32'(wr_cnt - mark), 32'd1);
        checkOutput("sram_wr_addr", 32'(last_wr_addr), 32'h1020002);
        checkOutput("sram_wr_d", 32'(last_wr_d), 32'h3344);
        checkOutput("sram_wr_ds", 32'(last_wr_ds), 32'h1);
        checkOutput("sram_dirty", 32'(dirty), 32'd1);
        applyStimulus(1'b0, 17'h00004, 32'd0, 8'h44, "sram_rd_lo", 20, lc, bl);
        applyStimulus(1'b0, 17'h00005, 32'd0, 8'hFF, "sram_rd_hi", 20, lc, bl);

        // No backup: handshake only
        backup_type = 2'd0;
        mark  = rd_cnt;
        mark2 = wr_cnt;
        applyStimulus(1'b0, 17'h00010, 32'd0, 8'hFF, "none_rd", 20, lc, bl);
        checkOutput("none_rd_latency", 32'(lc), 32'(LAT));
        applyStimulus(1'b1, 17'h00010, 32'hA5A5A5A5, 8'h00, "none_wr", 20, lc, bl);
        checkOutput("none_no_rd", 32'(rd_cnt - mark), 32'd0);
        checkOutput("none_no_wr", 32'(wr_cnt - mark2), 32'd0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
